fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning): FB_DEPTH, 19200, framebuffer entries (160x120); ADDR_W, 15, address width; PIX_W, 8, palette-index width.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 disp_req  in  1  display read request for the current cycle.
REQ-005 disp_addr  in  ADDR_W  display read address.
REQ-006 disp_rdata  out  PIX_W  registered display read data.
REQ-007 disp_rvalid  out  1  disp_rdata valid strobe.
REQ-008 wr_req  in  1  writer request; level, held with addr/data until ack.
REQ-009 wr_addr  in  ADDR_W  writer address.
REQ-010 wr_data  in  PIX_W  writer pixel index.
REQ-011 wr_ack  out  1  one-cycle pulse: write accepted.
REQ-012 wr_err  out  1  one-cycle pulse with wr_ack: address out of range, write dropped.
REQ-013 fill_start  in  1  pulse: begin whole-buffer fill.
REQ-014 fill_color  in  PIX_W  fill value, sampled on accepted fill_start.
REQ-015 fill_busy  out  1  high while fill in progress.
REQ-016 fill_done  out  1  one-cycle pulse after last fill write.
REQ-017 mem_addr  out  ADDR_W  registered memory address.
REQ-018 mem_we  out  1  registered write enable.
REQ-019 mem_wdata  out  PIX_W  registered write data.
REQ-020 mem_rdata  in  PIX_W  memory read data, valid one cycle after mem_addr.

Function
REQ-021 Arbitration each cycle (cycle N), fixed priority: display > writer > fill; result drives mem_* at N+1.
REQ-022 Display never stalls: disp_req at N -> mem_addr=disp_addr, mem_we=0 at N+1 -> disp_rdata=mem_rdata, disp_rvalid=1 at N+2 (latency 2, throughput 1/cycle).
REQ-023 disp_addr >= FB_DEPTH: no memory access issued, disp_rvalid still at N+2 with disp_rdata=0.
REQ-024 Writer granted at N when wr_req=1, disp_req=0, wr_ack=0: at N+1 mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
REQ-025 wr_req is masked in any cycle where wr_ack=1 (no duplicate write from a held request).
REQ-026 wr_addr >= FB_DEPTH: wr_ack and wr_err pulse together at N+1, mem_we=0.
REQ-027 Fill FSM states IDLE, FILL, DONE; IDLE->FILL on fill_start (latch fill_color, counter=0, fill_busy=1 next cycle).
REQ-028 In FILL, a slot is granted only when disp_req=0 and no writer grant; granted slot writes fill_color at counter, counter increments by 1.
REQ-029 FILL->DONE when address FB_DEPTH-1 is granted; DONE lasts one cycle: fill_done=1, fill_busy=0; DONE->IDLE.
REQ-030 fill_start while FILL or DONE is ignored; fill_color changes during FILL have no effect.
REQ-031 Writer and fill may interleave; writer write to an address not yet filled is later overwritten by fill (defined, not an error).
REQ-032 Idle cycles (no grant): mem_we=0, mem_addr holds last value.
REQ-033 Writer starvation under continuous disp_req is permitted; no timeout.

Reset
REQ-034 rst asserted (any time, incl. mid-fill or mid-handshake) asynchronously forces: FSM=IDLE, counter=0, fill_busy=0, fill_done=0, wr_ack=0, wr_err=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_rvalid=0, disp_rdata=0, pipeline valid bits=0.
REQ-035 An in-flight fill aborted by reset is not resumed; an unacked writer request is re-arbitrated after release.

Structure
REQ-036 Shared package fb_pkg holds FB_W=160, FB_H=120, FB_DEPTH, ADDR_W, PIX_W and fill state encoding.
REQ-037 One sub-module fb_fill_seq: fill FSM plus address counter, with grant input and request/addr/data outputs.

Verification
REQ-038 Display only: disp_req=1 at addrs 0,1,2 on consecutive cycles, mem_rdata=addr+5 -> disp_rdata 5,6,7 with rvalid at N+2..N+4.
REQ-039 Collision: wr_req (addr 100, data 0x3C) with disp_req=1 for 3 cycles -> no wr_ack until disp_req drops; then single wr_ack, one mem_we with addr 100 / data 0x3C.
REQ-040 Held wr_req across ack for 2 back-to-back writes (addr 10 then 11) -> exactly two wr_ack pulses, no duplicate write.
REQ-041 Out of range: wr_addr=19200 -> wr_ack=1, wr_err=1, mem_we=0; disp_addr=19200 -> rvalid with data 0.
REQ-042 Fill 0xAA with disp_req toggling 50% -> 19200 writes covering 0..19199 once each, fill_done once, fill_busy low afterward; second fill_start mid-fill ignored.
REQ-043 Reset at fill counter 5000 -> all outputs at reset values immediately, no further fill writes, new fill_start restarts from address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, bus widths and fill-sequencer state encoding.
// Imported by fb_fill_seq and fb_arbiter.
package fb_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned PIX_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fb_fill_seq.sv
// fb_fill_seq: whole-buffer fill sequencer. It walks the addresses 0..FB_DEPTH-1
// and advances one address per granted slot.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : pulse that begins a fill (accepted only in IDLE)
//   color     : fill value, latched when start is accepted
//   grant     : the arbiter consumed the current req/addr/data this cycle
//   req       : a fill write is wanted this cycle
//   addr      : address of the pending fill write
//   data      : value of the pending fill write
//   busy      : high while the fill is in progress
//   done      : one-cycle pulse after the last fill write is granted
module fb_fill_seq
  import fb_pkg::*;
#(
  parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned PIX_W    = fb_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  color,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fill_state_t       state;
  logic [ADDR_W-1:0] cnt;
  logic [PIX_W-1:0]  color_q;

  assign req  = (state == ST_FILL);
  assign addr = cnt;
  assign data = color_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      color_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FILL;
            cnt     <= '0;
            color_q <= color;
            busy    <= 1'b1;
          end
        end
        ST_FILL: begin
          if (grant) begin
            if (cnt == LAST_ADDR) begin
              state <= ST_DONE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer memory arbiter. There are three requesters,
// in fixed priority display > writer > fill. The arbitration decision made in
// cycle N drives the registered mem_* bus in cycle N+1.
//   clk, rst               : clock, asynchronous active-high reset
//   disp_req/disp_addr     : display read request (never stalled)
//   disp_rdata/disp_rvalid : read result, two cycles after the request
//   wr_req/wr_addr/wr_data : writer request, held until wr_ack
//   wr_ack/wr_err          : accept pulse; wr_err flags an out-of-range write that was dropped
//   fill_start/fill_color  : begin a whole-buffer fill with fill_color
//   fill_busy/fill_done    : fill in progress / completion pulse
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port (rdata follows mem_addr)
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned PIX_W    = fb_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [PIX_W-1:0]  disp_rdata,
  output logic              disp_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  // The range compare uses one extra bit so that FB_DEPTH == 2**ADDR_W would still work.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(FB_DEPTH);

  logic              disp_ok;
  logic              wr_ok;
  logic              wr_grant;
  logic              fill_grant;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic [PIX_W-1:0]  fill_data;
  logic              rd_valid;
  logic              rd_ok;

  assign disp_ok    = ({1'b0, disp_addr} < DEPTH_X);
  assign wr_ok      = ({1'b0, wr_addr} < DEPTH_X);
  // While wr_ack is high, a held request is masked so that it is not written twice.
  assign wr_grant   = wr_req & ~disp_req & ~wr_ack;
  // An out-of-range display request still owns its slot, so the fill waits for it.
  assign fill_grant = fill_req & ~disp_req & ~wr_grant;

  fb_fill_seq #(
    .FB_DEPTH (FB_DEPTH),
    .ADDR_W   (ADDR_W),
    .PIX_W    (PIX_W)
  ) u_fill (
    .clk   (clk),
    .rst   (rst),
    .start (fill_start),
    .color (fill_color),
    .grant (fill_grant),
    .req   (fill_req),
    .addr  (fill_addr),
    .data  (fill_data),
    .busy  (fill_busy),
    .done  (fill_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_ok       <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      // Read pipeline: stage 1 carries the address phase, stage 2 captures the data.
      rd_valid    <= disp_req;
      rd_ok       <= disp_ok;
      disp_rvalid <= rd_valid;
      disp_rdata  <= (rd_valid && rd_ok) ? mem_rdata : '0;

      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      mem_we <= 1'b0;
      if (disp_req) begin
        if (disp_ok) begin
          mem_addr <= disp_addr;
        end
      end else if (wr_grant) begin
        wr_ack <= 1'b1;
        if (wr_ok) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end else if (fill_grant) begin
        mem_we    <= 1'b1;
        mem_addr  <= fill_addr;
        mem_wdata <= fill_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter. The memory returns the low
// byte of mem_addr plus 5 on the cycle the address is presented.
module tb_fb_arbiter;

  localparam int DEPTH = 19200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [14:0] disp_addr = '0;
  logic [7:0]  disp_rdata;
  logic        disp_rvalid;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        wr_err;
  logic        fill_start = 1'b0;
  logic [7:0]  fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr[7:0] + 8'd5;

  fb_arbiter #(
    .FB_DEPTH (19200),
    .ADDR_W   (15),
    .PIX_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .fill_start  (fill_start),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_exp(input logic [14:0] a);
    return (a < 15'(DEPTH)) ? a[7:0] + 8'd5 : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req   = 1'b0;
    wr_req     = 1'b0;
    fill_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_addr"},    32'(mem_addr), 32'd0);
    chk({tag, "_mem_we"},      32'(mem_we), 32'd0);
    chk({tag, "_mem_wdata"},   32'(mem_wdata), 32'd0);
    chk({tag, "_wr_ack"},      32'(wr_ack), 32'd0);
    chk({tag, "_wr_err"},      32'(wr_err), 32'd0);
    chk({tag, "_rvalid"},      32'(disp_rvalid), 32'd0);
    chk({tag, "_rdata"},       32'(disp_rdata), 32'd0);
    chk({tag, "_fill_busy"},   32'(fill_busy), 32'd0);
    chk({tag, "_fill_done"},   32'(fill_done), 32'd0);
  endtask

  // Fill monitor, sampled on the falling edge
  logic mon_on    = 1'b0;
  logic mon_pdisp = 1'b0;
  int   wcnt[DEPTH];
  int   nwr = 0, bad_data = 0, oor_wr = 0, prio_viol = 0, done_pulses = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_we) begin
        nwr++;
        if (mem_addr < 15'(DEPTH)) wcnt[mem_addr]++;
        else oor_wr++;
        if (mem_wdata !== 8'hAA) bad_data++;
        if (mon_pdisp) prio_viol++;
      end
      if (fill_done) done_pulses++;
    end
    mon_pdisp = disp_req;
  end

  typedef struct {
    logic        dreq;
    logic [14:0] daddr;
    logic        wreq;
    logic [14:0] waddr;
    logic [7:0]  wdata;
    logic        e_we;
    logic        e_ack;
    logic        e_err;
    logic        chk_addr;
    logic [14:0] e_addr;
    logic        e_rv;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vecs[9];

  // random-phase state
  logic        p_dreq, pp_dreq, p_wreq, p_ack;
  logic [14:0] p_daddr, pp_daddr, p_waddr;
  logic [7:0]  p_wdata;
  int          acks_seen;
  int          cyc;
  int          cnt;
  int          missing;
  logic        hit;

  initial begin
    //                 dreq  daddr      wreq  waddr      wdata  we    ack   err   chka  e_addr     rv    rd
    vecs[0] = '{1'b1, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0,     1'b1, 8'h05};
    vecs[1] = '{1'b1, 15'd1234,  1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd1234,  1'b1, 8'hD7};
    vecs[2] = '{1'b0, 15'd0,     1'b1, 15'd100,   8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 15'd100,   1'b0, 8'h00};
    vecs[3] = '{1'b0, 15'd0,     1'b1, 15'd19200, 8'h09, 1'b0, 1'b1, 1'b1, 1'b1, 15'd100,   1'b0, 8'h00};
    vecs[4] = '{1'b1, 15'd19200, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd100,   1'b1, 8'h00};
    vecs[5] = '{1'b1, 15'd19199, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd19199, 1'b1, 8'h04};
    vecs[6] = '{1'b0, 15'd0,     1'b1, 15'd19199, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 15'd19199, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 15'd0,     1'b1, 15'd0,     8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 15'd0,     1'b0, 8'h00};
    vecs[8] = '{1'b0, 15'd5,     1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0,     1'b0, 8'h00};

    // Reset state
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 9; i++) begin
      disp_req  = vecs[i].dreq;
      disp_addr = vecs[i].daddr;
      wr_req    = vecs[i].wreq;
      wr_addr   = vecs[i].waddr;
      wr_data   = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_wr_ack", i), 32'(wr_ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].e_err));
      if (vecs[i].chk_addr)
        chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
      idle();
      tick();
      chk($sformatf("vec%0d_rvalid", i), 32'(disp_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        chk($sformatf("vec%0d_rdata", i), 32'(disp_rdata), 32'(vecs[i].e_rd));
    end
    tick();

    // Display stream at addresses 0,1,2 on consecutive cycles
    disp_req = 1'b1; disp_addr = 15'd0;
    tick();
    chk("disp3_addr0", 32'(mem_addr), 32'd0);
    chk("disp3_we0", 32'(mem_we), 32'd0);
    disp_addr = 15'd1;
    tick();
    chk("disp3_rv0", 32'(disp_rvalid), 32'd1);
    chk("disp3_rd0", 32'(disp_rdata), 32'd5);
    chk("disp3_addr1", 32'(mem_addr), 32'd1);
    disp_addr = 15'd2;
    tick();
    chk("disp3_rd1", 32'(disp_rdata), 32'd6);
    chk("disp3_addr2", 32'(mem_addr), 32'd2);
    idle();
    tick();
    chk("disp3_rv2", 32'(disp_rvalid), 32'd1);
    chk("disp3_rd2", 32'(disp_rdata), 32'd7);
    tick();
    chk("disp3_rv_end", 32'(disp_rvalid), 32'd0);

    // Collision: writer held off by three display cycles
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h3C;
    disp_req = 1'b1; disp_addr = 15'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("coll_noack%0d", i), 32'(wr_ack), 32'd0);
      chk($sformatf("coll_nowe%0d", i), 32'(mem_we), 32'd0);
    end
    disp_req = 1'b0;
    tick();
    chk("coll_ack", 32'(wr_ack), 32'd1);
    chk("coll_we", 32'(mem_we), 32'd1);
    chk("coll_addr", 32'(mem_addr), 32'd100);
    chk("coll_data", 32'(mem_wdata), 32'h3C);
    wr_req = 1'b0;
    tick();
    chk("coll_single_ack", 32'(wr_ack), 32'd0);
    chk("coll_single_we", 32'(mem_we), 32'd0);

    // Held request across ack: two back-to-back writes
    wr_req = 1'b1; wr_addr = 15'd10; wr_data = 8'h10;
    tick();
    chk("held_ack1", 32'(wr_ack), 32'd1);
    chk("held_addr1", 32'(mem_addr), 32'd10);
    wr_addr = 15'd11; wr_data = 8'h11;
    tick();
    chk("held_masked_ack", 32'(wr_ack), 32'd0);
    chk("held_masked_we", 32'(mem_we), 32'd0);
    tick();
    chk("held_ack2", 32'(wr_ack), 32'd1);
    chk("held_addr2", 32'(mem_addr), 32'd11);
    chk("held_data2", 32'(mem_wdata), 32'h11);
    wr_req = 1'b0;
    tick();
    chk("held_no_dup_ack", 32'(wr_ack), 32'd0);
    chk("held_no_dup_we", 32'(mem_we), 32'd0);
    tick();

    // Randomized display + writer traffic against the reference model
    p_dreq = 1'b0; pp_dreq = 1'b0; p_wreq = 1'b0; p_ack = 1'b0;
    p_daddr = '0; pp_daddr = '0; p_waddr = '0; p_wdata = '0;
    acks_seen = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      // writer accepted one cycle after a request that saw no display and no ack
      chk("rnd_ack", 32'(wr_ack), 32'(p_wreq && !p_dreq && !p_ack));
      if (p_wreq && !p_dreq && !p_ack) begin
        chk("rnd_err", 32'(wr_err), 32'(p_waddr >= 15'(DEPTH)));
        if (p_waddr < 15'(DEPTH)) begin
          chk("rnd_we", 32'(mem_we), 32'd1);
          chk("rnd_waddr", 32'(mem_addr), 32'(p_waddr));
          chk("rnd_wdata", 32'(mem_wdata), 32'(p_wdata));
        end else begin
          chk("rnd_we_oor", 32'(mem_we), 32'd0);
        end
      end else begin
        chk("rnd_we_idle", 32'(mem_we), 32'd0);
        chk("rnd_err_idle", 32'(wr_err), 32'd0);
      end
      if (p_dreq && p_daddr < 15'(DEPTH)) chk("rnd_raddr", 32'(mem_addr), 32'(p_daddr));
      chk("rnd_rvalid", 32'(disp_rvalid), 32'(pp_dreq));
      if (pp_dreq) chk("rnd_rdata", 32'(disp_rdata), 32'(rd_exp(pp_daddr)));

      // next stimulus
      pp_dreq  = p_dreq;
      pp_daddr = p_daddr;
      disp_req  = ($urandom_range(0, 99) < 60);
      disp_addr = 15'($urandom_range(0, DEPTH + 40));
      if (wr_ack) begin
        acks_seen++;
        if ($urandom_range(0, 1) == 1) begin
          wr_addr = ($urandom_range(0, 9) == 0) ? 15'(DEPTH + $urandom_range(0, 20))
                                               : 15'($urandom_range(0, DEPTH - 1));
          wr_data = 8'($urandom_range(0, 255));
        end else begin
          wr_req = 1'b0;
        end
      end else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = ($urandom_range(0, 9) == 0) ? 15'(DEPTH + $urandom_range(0, 20))
                                             : 15'($urandom_range(0, DEPTH - 1));
        wr_data = 8'($urandom_range(0, 255));
      end
      p_dreq  = disp_req;
      p_daddr = disp_addr;
      p_wreq  = wr_req;
      p_waddr = wr_addr;
      p_wdata = wr_data;
      p_ack   = wr_ack;
    end
    chk("rnd_some_acks", 32'(acks_seen > 20), 32'd1);
    idle();
    tick();
    tick();
    tick();

    // Whole-buffer fill with 50% display load and an ignored second start
    for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
    mon_on = 1'b1;
    fill_start = 1'b1; fill_color = 8'hAA;
    tick();
    fill_start = 1'b0;
    chk("fill_busy_start", 32'(fill_busy), 32'd1);
    cyc = 0;
    while (cyc < 60000 && fill_done !== 1'b1) begin
      disp_req  = ($urandom_range(0, 1) == 1);
      disp_addr = 15'($urandom_range(0, DEPTH - 1));
      if (cyc == 1000) begin
        fill_start = 1'b1;
        fill_color = 8'h55;
      end else begin
        fill_start = 1'b0;
      end
      tick();
      cyc++;
      if (cyc == 1001) chk("fill_busy_midstart", 32'(fill_busy), 32'd1);
    end
    chk("fill_done_seen", 32'(fill_done), 32'd1);
    chk("fill_busy_at_done", 32'(fill_busy), 32'd0);
    idle();
    tick();
    chk("fill_done_one_cycle", 32'(fill_done), 32'd0);
    chk("fill_busy_after", 32'(fill_busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    mon_on = 1'b0;
    missing = 0;
    for (int i = 0; i < DEPTH; i++) if (wcnt[i] != 1) missing++;
    chk("fill_write_count", 32'(nwr), 32'(DEPTH));
    chk("fill_addr_not_once", 32'(missing), 32'd0);
    chk("fill_bad_data", 32'(bad_data), 32'd0);
    chk("fill_oor_writes", 32'(oor_wr), 32'd0);
    chk("fill_prio_viol", 32'(prio_viol), 32'd0);
    chk("fill_done_pulses", 32'(done_pulses), 32'd1);

    // Reset in the middle of a fill, with an unacked writer request pending
    fill_start = 1'b1; fill_color = 8'h77;
    tick();
    fill_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (mem_we && mem_addr == 15'd5000) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_fill_reached_5000", 32'(hit), 32'd1);
    disp_req = 1'b1; disp_addr = 15'd7;
    wr_req = 1'b1; wr_addr = 15'd300; wr_data = 8'h11;
    #2 rst = 1'b1;
    #1 chk_reset_vals("midfill_reset");
    tick();
    tick();
    chk("rst_hold_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_wr_wait_ack%0d", i), 32'(wr_ack), 32'd0);
      chk($sformatf("rst_wr_wait_we%0d", i), 32'(mem_we), 32'd0);
    end
    disp_req = 1'b0;
    tick();
    chk("rst_wr_rearb_ack", 32'(wr_ack), 32'd1);
    chk("rst_wr_rearb_addr", 32'(mem_addr), 32'd300);
    chk("rst_wr_rearb_data", 32'(mem_wdata), 32'h11);
    wr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we) cnt++;
    end
    chk("rst_no_fill_resume", 32'(cnt), 32'd0);
    chk("rst_busy_low", 32'(fill_busy), 32'd0);
    fill_start = 1'b1; fill_color = 8'h22;
    tick();
    fill_start = 1'b0;
    chk("refill_busy", 32'(fill_busy), 32'd1);
    tick();
    chk("refill_we0", 32'(mem_we), 32'd1);
    chk("refill_addr0", 32'(mem_addr), 32'd0);
    chk("refill_data0", 32'(mem_wdata), 32'h22);
    tick();
    chk("refill_addr1", 32'(mem_addr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
